// File: rtl/codificador_2de5_serial_if.sv
// Digit handshake between a producer and the 2-of-5 serial encoder.
//   digit       : BCD digit offered by the producer
//   digit_valid : producer has a digit this cycle
//   digit_ready : encoder can take a digit this cycle
interface codificador_2de5_serial_if;
  logic [3:0] digit;
  logic       digit_valid;
  logic       digit_ready;

  modport master (output digit, output digit_valid, input digit_ready);
  modport slave  (input digit, input digit_valid, output digit_ready);
endinterface

// File: rtl/codificador_2de5_serial.sv
// 2-of-5 serial encoder: takes a BCD digit over a valid/ready handshake,
// encodes it with weights 7,4,2,1,0 and sends it as a framed serial word
// (start bit 1, E1..E5, stop bit 0), each bit held BIT_CYCLES clocks.
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   digitIf    : digit / digit_valid / digit_ready handshake (slave side)
//   tx_line    : serial line, idle 0
//   code_out   : last valid encoded word {E1,E2,E3,E4,E5}
//   busy       : frame in progress
//   err        : one-cycle pulse when a digit above 9 is rejected
module codificador_2de5_serial #(
  parameter int unsigned BIT_CYCLES = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  codificador_2de5_serial_if.slave        digitIf,
  output logic                            tx_line,
  output logic [4:0]                      code_out,
  output logic                            busy,
  output logic                            err
);

  localparam int unsigned CNT_W = 8;
  localparam int unsigned BIT_W = 3;
  localparam int unsigned WORD_W = 5;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t              state;
  logic [CNT_W-1:0]    cycleCnt;
  logic [BIT_W-1:0]    bitIdx;
  logic [WORD_W-1:0]   shiftReg;
  logic                digitReady;
  logic                lastCycle;

  // Weighted 2-of-5 code; zero uses 7+4 by convention.
  function automatic logic [WORD_W-1:0] encode(input logic [3:0] d);
    logic [WORD_W-1:0] w;
    w = '0;
    case (d)
      4'd0: w = 5'b11000;
      4'd1: w = 5'b00011;
      4'd2: w = 5'b00101;
      4'd3: w = 5'b00110;
      4'd4: w = 5'b01001;
      4'd5: w = 5'b01010;
      4'd6: w = 5'b01100;
      4'd7: w = 5'b10001;
      4'd8: w = 5'b10010;
      4'd9: w = 5'b10100;
      default: w = '0;
    endcase
    return w;
  endfunction

  assign digitIf.digit_ready = digitReady;
  assign lastCycle = (cycleCnt == CNT_W'(BIT_CYCLES - 1));

  // Frame sequencer with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cycleCnt   <= '0;
      bitIdx     <= '0;
      shiftReg   <= '0;
      digitReady <= 1'b1;
      tx_line    <= 1'b0;
      code_out   <= '0;
      busy       <= 1'b0;
      err        <= 1'b0;
    end else begin
      err <= 1'b0;
      case (state)
        IDLE: begin
          if (digitIf.digit_valid && digitReady) begin
            if (digitIf.digit > 4'd9) begin
              err <= 1'b1;
            end else begin
              code_out   <= encode(digitIf.digit);
              shiftReg   <= encode(digitIf.digit);
              state      <= START;
              busy       <= 1'b1;
              digitReady <= 1'b0;
              tx_line    <= 1'b1;
              cycleCnt   <= '0;
              bitIdx     <= '0;
            end
          end
        end
        START: begin
          if (lastCycle) begin
            cycleCnt <= '0;
            bitIdx   <= '0;
            state    <= DATA;
            tx_line  <= shiftReg[WORD_W-1];
            shiftReg <= {shiftReg[WORD_W-2:0], 1'b0};
          end else begin
            cycleCnt <= cycleCnt + CNT_W'(1);
          end
        end
        DATA: begin
          if (lastCycle) begin
            cycleCnt <= '0;
            if (bitIdx == BIT_W'(WORD_W - 1)) begin
              bitIdx  <= '0;
              state   <= STOP;
              tx_line <= 1'b0;
            end else begin
              bitIdx   <= bitIdx + BIT_W'(1);
              tx_line  <= shiftReg[WORD_W-1];
              shiftReg <= {shiftReg[WORD_W-2:0], 1'b0};
            end
          end else begin
            cycleCnt <= cycleCnt + CNT_W'(1);
          end
        end
        STOP: begin
          if (lastCycle) begin
            cycleCnt   <= '0;
            state      <= IDLE;
            busy       <= 1'b0;
            digitReady <= 1'b1;
          end else begin
            cycleCnt <= cycleCnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_codificador_2de5_serial.sv
// Bench for the 2-of-5 serial encoder: one instance at BIT_CYCLES=4 with a
// frame-capturing monitor fed by an expected-word queue, and one instance at
// BIT_CYCLES=1 for the mid-frame reset and single-cycle-bit frames.
module tb_codificador_2de5_serial;
  localparam int unsigned BC_A = 4;
  localparam int unsigned BC_B = 1;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  codificador_2de5_serial_if ifA();
  codificador_2de5_serial_if ifB();

  logic       txA, busyA, errA;
  logic [4:0] codeA;
  logic       txB, busyB, errB;
  logic [4:0] codeB;

  codificador_2de5_serial #(.BIT_CYCLES(BC_A)) dutA (
    .clk(clk), .rst_n(rst_n), .digitIf(ifA.slave),
    .tx_line(txA), .code_out(codeA), .busy(busyA), .err(errA));

  codificador_2de5_serial #(.BIT_CYCLES(BC_B)) dutB (
    .clk(clk), .rst_n(rst_n), .digitIf(ifB.slave),
    .tx_line(txB), .code_out(codeB), .busy(busyB), .err(errB));

  int nChecks = 0;
  int nFails  = 0;

  logic [4:0] qA[$];
  logic [6:0] qB[$];

  int framesA = 0;
  int idleCnt = 0;
  bit gapChk = 1'b0;
  bit prevInSweep = 1'b0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Reference: the two weight positions (7,4,2,1,0) whose sum is the digit; 0 -> 7+4.
  function automatic logic [4:0] refCode(input int d);
    int wts[5];
    logic [4:0] w;
    wts = '{7, 4, 2, 1, 0};
    w = '0;
    for (int i = 0; i < 5; i++)
      for (int j = i + 1; j < 5; j++)
        if ((wts[i] + wts[j] == d) || (d == 0 && wts[i] + wts[j] == 11)) begin
          w = '0;
          w[4-i] = 1'b1;
          w[4-j] = 1'b1;
        end
    return w;
  endfunction

  // Offer a digit on A; returns one clock after the transfer edge.
  task automatic sendA(input logic [3:0] d, input bit keep);
    int n;
    ifA.digit = d;
    ifA.digit_valid = 1'b1;
    n = 0;
    while (!ifA.digit_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) chk("ready timeout", 0, 1);
    if (d <= 4'd9) qA.push_back(refCode(int'(d)));
    @(posedge clk); #1;
    if (!keep) ifA.digit_valid = 1'b0;
  endtask

  // Frame monitor for instance A.
  initial begin : monA
    bit prev;
    logic [6:0] frame;
    logic [4:0] exp;
    int busyCnt;
    bit slotBad;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev = 1'b0;
      end else if (busyA && !prev) begin
        if (gapChk && prevInSweep) chk("frame gap", idleCnt, 1);
        idleCnt = 0;
        busyCnt = 0;
        slotBad = 1'b0;
        frame = '0;
        if (qA.size() == 0) begin
          chk("unexpected frame", 0, 1);
          exp = '0;
        end else begin
          exp = qA.pop_front();
        end
        chk("code_out", codeA, exp);
        for (int s = 0; s < 7; s++)
          for (int c = 0; c < int'(BC_A); c++) begin
            if (s != 0 || c != 0) @(negedge clk);
            if (busyA) busyCnt++;
            if (c == 0) frame[6-s] = txA;
            else if (txA !== frame[6-s]) slotBad = 1'b1;
          end
        chk("frame bits", frame, {1'b1, exp, 1'b0});
        chk("slot hold", slotBad, 0);
        chk("busy length", busyCnt, 7 * BC_A);
        @(negedge clk);
        chk("busy after frame", busyA, 0);
        chk("ready after frame", ifA.digit_ready, 1);
        idleCnt = 1;
        prevInSweep = gapChk;
        framesA++;
        prev = 1'b0;
      end else begin
        if (!busyA) idleCnt++;
        prev = busyA;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin : main
    int f0;
    logic [6:0] got;
    ifA.digit = '0; ifA.digit_valid = 1'b0;
    ifB.digit = '0; ifB.digit_valid = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    #1;
    chk("rst tx", txA, 0);
    chk("rst code", codeA, 0);
    chk("rst ready", ifA.digit_ready, 1);
    chk("rst busy", busyA, 0);
    chk("rst err", errA, 0);
    chk("rst ready B", ifB.digit_ready, 1);
    @(posedge clk); #1;

    // Single digit 0
    sendA(4'd0, 1'b0);
    chk("start tx", txA, 1);
    repeat (7 * BC_A + 5) @(posedge clk);
    #1;
    chk("frames after 0", framesA, 1);

    // Back-to-back sweep with valid held high
    f0 = framesA;
    gapChk = 1'b1;
    for (int d = 0; d < 10; d++) sendA(4'(d), 1'b1);
    ifA.digit_valid = 1'b0;
    repeat (7 * BC_A + 5) @(posedge clk);
    #1;
    gapChk = 1'b0;
    chk("sweep frames", framesA - f0, 10);
    chk("sweep queue empty", qA.size(), 0);

    // Invalid digit
    f0 = framesA;
    sendA(4'd12, 1'b0);
    chk("invalid err", errA, 1);
    chk("invalid code kept", codeA, refCode(9));
    chk("invalid tx", txA, 0);
    chk("invalid ready", ifA.digit_ready, 1);
    chk("invalid busy", busyA, 0);
    @(posedge clk); #1;
    chk("err one cycle", errA, 0);

    // valid pulsed mid-frame is ignored
    sendA(4'd3, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    chk("ready in frame", ifA.digit_ready, 0);
    ifA.digit = 4'd5;
    ifA.digit_valid = 1'b1;
    @(posedge clk); #1;
    ifA.digit_valid = 1'b0;
    chk("code mid frame", codeA, refCode(3));
    repeat (7 * BC_A + 10) @(posedge clk);
    #1;
    chk("pulse frames", framesA - f0, 1);
    chk("pulse code kept", codeA, refCode(3));
    chk("pulse queue empty", qA.size(), 0);

    // Instance B: reset during E3 of digit 9
    ifB.digit = 4'd9;
    ifB.digit_valid = 1'b1;
    @(posedge clk); #1;
    ifB.digit_valid = 1'b0;
    chk("B start", txB, 1);
    chk("B code 9", codeB, refCode(9));
    repeat (3) @(posedge clk);
    #1;
    chk("B E3 bit", txB, 1);
    rst_n = 1'b0;
    #1;
    chk("B rst tx", txB, 0);
    chk("B rst code", codeB, 0);
    chk("B rst busy", busyB, 0);
    chk("B rst ready", ifB.digit_ready, 1);
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;

    qB.push_back({1'b1, refCode(7), 1'b0});
    ifB.digit = 4'd7;
    ifB.digit_valid = 1'b1;
    @(posedge clk); #1;
    ifB.digit_valid = 1'b0;
    got = '0;
    for (int i = 0; i < 7; i++) begin
      got[6-i] = txB;
      @(posedge clk); #1;
    end
    chk("B frame 7", got, qB.pop_front());
    chk("B busy end", busyB, 0);
    chk("B ready end", ifB.digit_ready, 1);
    chk("B tx idle", txB, 0);

    $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFails);
    $finish;
  end
endmodule

// File: doc/codificador_2de5_serial.md
Name: codificador_2de5_serial

Overview:
- Transmit-side counterpart of the 2-of-5 column decoder.
- Accepts a BCD digit over a valid/ready handshake and encodes it into a 2-of-5 code word (E1..E5).
- Serialises the word onto a single line using a framed, fixed-rate protocol, so a remote receiver/decoder can rebuild E1..E5.
- Also presents the encoded word in parallel for local display logic.

Parameters:
BIT_CYCLES, 4, clock cycles per transmitted bit (legal range 1..255)

Ports:
clk  input  1  system clock, rising-edge
rst_n  input  1  asynchronous active-low reset
digit  input  4  BCD digit to encode
digit_valid  input  1  digit is valid this cycle
digit_ready  output  1  block can accept a digit this cycle
tx_line  output  1  serial line; idle level 0
code_out  output  5  last valid encoded word {E1,E2,E3,E4,E5}
busy  output  1  frame in progress
err  output  1  one-cycle pulse: invalid digit (>9) rejected

Behaviour:
- Clocking and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: state IDLE; tx_line=0, code_out=00000, busy=0, err=0, digit_ready=1; bit and cycle counters cleared.
- All outputs are registered. digit_ready is decoded from state and is 1 only in IDLE.
- Encoding: weights E1..E5 = 7,4,2,1,0, giving {E1..E5}:
  0=11000, 1=00011, 2=00101, 3=00110, 4=01001, 5=01010, 6=01100, 7=10001, 8=10010, 9=10100.
  Every valid word has exactly two 1s.
- Handshake: a transfer occurs when digit_valid && digit_ready at a rising edge. digit is sampled only at that edge. While digit_ready=0, digit_valid is ignored and nothing is queued.
- Invalid digit (10..15):
  - The transfer completes.
  - err=1 for exactly the next cycle.
  - State stays IDLE; code_out and tx_line are unchanged; no frame is sent.
- Valid digit:
  - The next cycle code_out holds the new word, busy=1 and state goes to START.
- State machine: IDLE -> START -> DATA -> STOP -> IDLE.
  - START: tx_line=1 for BIT_CYCLES cycles.
  - DATA: 5 bits, E1 first, E5 last; each bit is held BIT_CYCLES cycles. A bit index (0..4) advances when the cycle counter reaches BIT_CYCLES-1.
  - STOP: tx_line=0 for BIT_CYCLES cycles, then return to IDLE with busy=0 and digit_ready=1.
- Frame timing:
  - The frame is 7*BIT_CYCLES cycles from the first START cycle to the first IDLE cycle.
  - Accept-to-first-start-bit latency is 1 cycle.
  - A new transfer may occur in the first IDLE cycle; the next frame's START follows with no gap beyond STOP.
- Counter widths: the cycle counter is 8 bits and the bit index is 3 bits. The counters wrap to 0 at each bit boundary and never overflow.
- BIT_CYCLES=1: every state bit lasts one cycle and the frame is 7 cycles.
- Reset mid-frame: the block immediately returns to reset values. A partial frame is abandoned (the line returns to 0) and code_out clears.
- A held digit_valid in IDLE transfers a new digit every frame.

Test Plan:
- Reset with rst_n=0 for 3 cycles, released asynchronously mid-cycle -> tx_line=0, code_out=00000, digit_ready=1, busy=0, err=0.
- BIT_CYCLES=4, digit=0 accepted -> code_out=11000 next cycle; tx_line sequence per 4-cycle slot is 1,1,1,0,0,0,0; busy high for 28 cycles; digit_ready returns 1 after 28.
- Sweep digits 0..9 back-to-back with digit_valid held high -> each code_out has exactly two 1s matching the table; frames are contiguous; no digit is lost or duplicated.
- digit=12 accepted in IDLE -> err=1 for one cycle; code_out keeps its previous value; tx_line stays 0; digit_ready stays 1.
- digit_valid pulsed during a frame (digit=5) -> ignored; frame in progress completes unchanged; code_out unchanged.
- rst_n asserted during DATA bit E3 of digit 9 -> tx_line=0 and code_out=00000 immediately; after release, digit 7 sends a clean frame 1,1,0,0,0,1,0 with BIT_CYCLES=1.
